// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared constants and types for the instruction-memory boot loader.
//   ADDR_W    : byte address width of instruction memory
//   DATA_W    : instruction word width
//   MAX_WORDS : memory capacity in words
//   LEN_W     : width of the load_len word count
//   NUM_LANES : bytes per instruction word
//   NOP       : instruction presented to the core while it is held
//   state_t   : loader FSM states
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_WORDS = 256;
    localparam int LEN_W     = 9;
    localparam int NUM_LANES = DATA_W / 8;

    // addi x0, x0, 0
    localparam logic [DATA_W-1:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_t;

    // A load is legal only for 1..MAX_WORDS words.
    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Packs a byte stream little-endian into a word: the first byte of a word
// lands in bits [7:0]. The lane counter wraps after the last lane.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart at lane 0 (new load)
//   byte_en     : a byte is being consumed this cycle
//   byte_in     : the byte
//   word        : assembled lanes (complete the cycle after word_valid)
//   word_valid  : this cycle's byte completes the word
// ---------------------------------------------------------------------------
module byte_packer #(
    parameter int NUM_LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_en,
    input  logic [7:0]             byte_in,
    output logic [NUM_LANES*8-1:0] word,
    output logic                   word_valid
);

    localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_LANES - 1);

    logic [CNT_W-1:0]                lane;
    logic [NUM_LANES-1:0][7:0]       lanes_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane    <= '0;
            lanes_q <= '0;
        end else if (clear) begin
            // stale lane data is harmless: every lane is rewritten before use
            lane <= '0;
        end else if (byte_en) begin
            lanes_q[lane] <= byte_in;
            lane          <= (lane == LAST) ? '0 : lane + 1'b1;
        end
    end

    assign word       = lanes_q;
    assign word_valid = byte_en && (lane == LAST);

endmodule

// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
// Boot-time loader and fetch-port owner for the instruction memory.
// A program arrives as a byte stream, is packed into little-endian words and
// written to consecutive word addresses; afterwards the memory address port
// is handed to the core PC with a combinational fetch path.
//
// Optional feature (macro IMEM_LOAD_CHECKSUM_EN): after the last program word
// one extra word is streamed in and compared against the wrapping 32-bit sum
// of the program words; match -> RUN, mismatch -> ERROR. It is never written.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle load request, load_len sampled with it
//   load_len     : program length in words (1..MAX_WORDS legal)
//   byte_in, byte_valid, byte_ready : byte stream handshake
//   core_pc      : core fetch address
//   core_instr   : fetched instruction, NOP while the core is held
//   core_stall   : core must not advance
//   mem_addr, mem_wdata, mem_we, mem_rdata : instruction memory port
//   done         : program loaded and core running
//   error        : bad length or checksum failure
// ---------------------------------------------------------------------------
module imem_load_ctrl
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] core_pc,
    output logic [DATA_W-1:0] core_instr,
    output logic              core_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              error
);

    state_t             state, state_n;
    logic [LEN_W-1:0]   word_idx;
    logic [LEN_W-1:0]   len_q;
    logic               byte_acc;
    logic               launch;
    logic               bad_start;
    logic               last_word;
    logic [DATA_W-1:0]  word;
    logic               word_valid;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic               ck_phase;   // the word being received is the checksum
    logic [DATA_W-1:0]  csum;
    logic [DATA_W-1:0]  ck_word;
`endif

    // Ready is a pure decode of the state register, so it never depends on
    // byte_valid and the handshake has no combinational loop.
    assign byte_ready = (state == S_LOAD);
    assign byte_acc   = byte_valid && byte_ready;

    // start is only honoured where the loader is not mid-transfer
    assign launch    = start && len_ok(load_len) &&
                       (state inside {S_IDLE, S_RUN, S_ERROR});
    assign bad_start = start && !len_ok(load_len) &&
                       (state inside {S_IDLE, S_RUN, S_ERROR});

    assign last_word = ((word_idx + LEN_W'(1)) == len_q);

    byte_packer #(
        .NUM_LANES (NUM_LANES)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (launch),
        .byte_en    (byte_acc),
        .byte_in    (byte_in),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef IMEM_LOAD_CHECKSUM_EN
    // The checksum is judged on the cycle its last byte arrives, so the top
    // lane comes straight from the stream rather than the packer register.
    assign ck_word = {byte_in, word[23:0]};
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // -----------------------------------------------------------------------
    // Load bookkeeping: word index, latched length, checksum accumulator
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx <= '0;
            len_q    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            ck_phase <= 1'b0;
            csum     <= '0;
`endif
        end else if (launch) begin
            word_idx <= '0;
            len_q    <= load_len;
`ifdef IMEM_LOAD_CHECKSUM_EN
            ck_phase <= 1'b0;
            csum     <= '0;
`endif
        end else if (state == S_WRITE) begin
            word_idx <= word_idx + LEN_W'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= csum + word;
            if (last_word) ck_phase <= 1'b1;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        core_stall = 1'b1;
        core_instr = NOP;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        done       = 1'b0;
        error      = 1'b0;

        case (state)
            S_IDLE: begin
                if (launch)         state_n = S_LOAD;
                else if (bad_start) state_n = S_ERROR;
            end

            S_LOAD: begin
                if (word_valid) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    if (ck_phase)
                        state_n = (ck_word == csum) ? S_RUN : S_ERROR;
                    else
                        state_n = S_WRITE;
`else
                    state_n = S_WRITE;
`endif
                end
            end

            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = {word_idx[ADDR_W-3:0], 2'b00};
                mem_wdata = word;
`ifdef IMEM_LOAD_CHECKSUM_EN
                // after the last program word the checksum word follows
                state_n   = S_LOAD;
`else
                state_n   = last_word ? S_RUN : S_LOAD;
`endif
            end

            S_RUN: begin
                // single-cycle core: fetch is a straight combinational path
                mem_addr   = core_pc;
                core_instr = mem_rdata;
                core_stall = 1'b0;
                done       = 1'b1;
                if (launch)         state_n = S_LOAD;
                else if (bad_start) state_n = S_ERROR;
            end

            S_ERROR: begin
                error = 1'b1;
                if (launch)         state_n = S_LOAD;
                else if (bad_start) state_n = S_ERROR;
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid, byte_ready;
    logic [8:0]  load_len;
    logic [7:0]  byte_in;
    logic [9:0]  core_pc, mem_addr;
    logic [31:0] core_instr, mem_wdata, mem_rdata;
    logic        core_stall, mem_we, done, error;

    always #5 clk = ~clk;

    imem_load_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .core_pc(core_pc), .core_instr(core_instr), .core_stall(core_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .done(done), .error(error)
    );

    // instruction memory: combinational read, written on mem_we
    logic [31:0] tb_mem [0:255];
    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;

    // model: program bytes, expected write stream, expected loaded image
    logic [7:0]  prog [0:1023];
    logic [31:0] img  [0:255];
    logic [9:0]  exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    int tests = 0, fails = 0, n_we = 0, nwe0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                n_we++;
                if (exp_addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got addr %h expected no write", mem_addr);
                end else begin
                    check("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                    check("wr_data", mem_wdata, exp_data_q.pop_front());
                end
            end else if (!done) begin
                check("idle_addr", 32'(mem_addr), 32'h0);
            end
            if (done) begin
                check("run_stall", 32'(core_stall), 32'h0);
                check("run_addr", 32'(mem_addr), 32'(core_pc));
                check("run_instr", core_instr, img[core_pc[9:2]]);
            end else begin
                check("hold_stall", 32'(core_stall), 32'h1);
                check("hold_instr", core_instr, NOP);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_pulse(input int len);
        start = 1'b1; load_len = 9'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        int   k;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1; byte_in = b; r = 1'b0; k = 0;
        while (!r && k < 64) begin
            @(negedge clk); r = byte_ready;
            @(posedge clk); #1; k++;
        end
        byte_valid = 1'b0;
        if (!r) begin
            tests++; fails++;
            $display("FAIL byte_accept_timeout: got no ready in %0d cycles expected ready", k);
        end
    endtask

    task automatic load_prog(input int len, input bit thr, input bit corrupt);
        logic [31:0] w;
`ifdef IMEM_LOAD_CHECKSUM_EN
        logic [31:0] sum;
        sum = 0;
`endif
        for (int i = 0; i < len; i++) begin
            w = {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
            exp_addr_q.push_back(10'(4*i));
            exp_data_q.push_back(w);
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum = sum + w;
`endif
        end
        start_pulse(len);
        check("start_ready", 32'(byte_ready), 32'h1);
        check("start_done_low", 32'(done), 32'h0);
        check("start_stall", 32'(core_stall), 32'h1);
        for (int i = 0; i < 4*len; i++) begin
            send_byte(prog[i], thr ? int'($urandom_range(0, 3)) : 0);
            if (!thr && (i % 4) == 3) begin
                check("we_after_4th", 32'(mem_we), 32'h1);
                check("ready_low_write", 32'(byte_ready), 32'h0);
            end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (corrupt) sum = sum + 1;
        for (int j = 0; j < 4; j++) send_byte(sum[8*j +: 8], 0);
        check("ck_done", 32'(done), 32'(!corrupt));
        check("ck_error", 32'(error), 32'(corrupt));
`else
        tick();
        check("done_after_write", 32'(done), 32'(!corrupt));
        check("error_clear", 32'(error), 32'h0);
`endif
        check("queue_drained", 32'(exp_addr_q.size()), 32'h0);
        if (done)
            for (int i = 0; i < len; i++)
                img[i] = {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        reset = 1'b1; start = 1'b0; load_len = '0; byte_in = '0;
        byte_valid = 1'b0; core_pc = '0;
        for (int i = 0; i < 256; i++) begin tb_mem[i] = '0; img[i] = '0; end
        repeat (2) tick();
        check("rst_ready", 32'(byte_ready), 32'h0);
        check("rst_stall", 32'(core_stall), 32'h1);
        check("rst_instr", core_instr, 32'h00000013);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        reset = 1'b0;
        tick();

        // nominal two-word load
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'hB3; prog[5] = 8'h00; prog[6] = 8'h20; prog[7] = 8'h00;
        load_prog(2, 1'b0, 1'b0);
        check("model_word1", img[1], 32'h002000B3);
        core_pc = 10'd4; #1;
        check("nom_pc4", core_instr, 32'h002000B3);
        core_pc = 10'd0; #1;
        check("nom_pc0", core_instr, 32'h00000013);

        // throttled 43-word load, reloaded from RUN
        for (int i = 0; i < 172; i++) prog[i] = 8'(i*37 + 5);
        nwe0 = n_we;
        load_prog(43, 1'b1, 1'b0);
        check("thr_we_count", 32'(n_we - nwe0), 32'd43);
        core_pc = 10'd168; #1;
        check("thr_last_word", core_instr, 32'hBC97724D);

        // bad lengths
        nwe0 = n_we;
        start_pulse(0);
        check("len0_error", 32'(error), 32'h1);
        check("len0_stall", 32'(core_stall), 32'h1);
        check("len0_ready", 32'(byte_ready), 32'h0);
        start_pulse(257);
        check("len257_error", 32'(error), 32'h1);
        check("len257_done", 32'(done), 32'h0);
        repeat (3) tick();
        check("bad_len_no_we", 32'(n_we - nwe0), 32'h0);

        // reset after 6 bytes, with an ignored start mid-load
        prog[0] = 8'hAA; prog[1] = 8'hBB; prog[2] = 8'hCC; prog[3] = 8'hDD;
        prog[4] = 8'h11; prog[5] = 8'h22;
        exp_addr_q.push_back(10'd0); exp_data_q.push_back(32'hDDCCBBAA);
        start_pulse(2);
        send_byte(prog[0], 0); send_byte(prog[1], 0);
        start_pulse(0);
        check("ignored_start_err", 32'(error), 32'h0);
        check("ignored_start_rdy", 32'(byte_ready), 32'h1);
        for (int i = 2; i < 6; i++) send_byte(prog[i], 0);
        reset = 1'b1;
        tick();
        check("midrst_ready", 32'(byte_ready), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_we", 32'(mem_we), 32'h0);
        reset = 1'b0;
        tick();
        check("midrst_drained", 32'(exp_addr_q.size()), 32'h0);
        prog[0] = 8'h78; prog[1] = 8'h56; prog[2] = 8'h34; prog[3] = 8'h12;
        load_prog(1, 1'b0, 1'b0);
        core_pc = 10'd0; #1;
        check("post_rst_word", core_instr, 32'h12345678);

        // reload from RUN
        prog[0] = 8'h93; prog[1] = 8'h00; prog[2] = 8'h10; prog[3] = 8'h00;
        load_prog(1, 1'b0, 1'b0);
        #1;
        check("reload_word", core_instr, 32'h00100093);

`ifdef IMEM_LOAD_CHECKSUM_EN
        prog[0] = 8'h01; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h02; prog[5] = 8'h00; prog[6] = 8'h00; prog[7] = 8'h00;
        load_prog(2, 1'b0, 1'b0);
        load_prog(2, 1'b0, 1'b1);
        check("ck_bad_error", 32'(error), 32'h1);
        check("ck_bad_done", 32'(done), 32'h0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
